mmu_tx_bd_dispatch: RTL

- Parametrised successor to the MMU TX BD path.
- Takes one inbound BD stream and steers each single-beat BD to one of NUM_CH outbound AXIS channels (kernels, mmu_rx, ...), using a channel-id field inside the BD.
- Adds per-channel buffering, a per-channel outstanding-BD credit limit released by response pulses, runtime channel enable, drop-or-stall handling of bad BDs, and a flush mode.

---
 rtl/mmu_tx_pkg.sv | 26 ++
 rtl/bd_ch_fifo.sv | 50 +++++
 rtl/mmu_tx_bd_dispatch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mmu_tx_pkg.sv
// Shared types and constants for the MMU TX BD dispatcher.
package mmu_tx_pkg;

    // Dispatcher FSM; encoding is visible on sta_fsm.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_t;

    // Default position of the channel-id field inside a BD.
    localparam int CH_LSB_DEF = 480;
    localparam int CHW_DEF    = 3;

    // Width of each per-channel outstanding counter on sta_outs.
    localparam int OUTS_W = 5;

    // Ceiling log2, for sizing from parameters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bd_ch_fifo.sv
// First-word-fall-through FIFO for one output channel, with occupancy count and sync clear.
module bd_ch_fifo #(
    parameter int W  = 512,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [AW:0]   cnt
);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic          full, wr, rd;

    assign empty = (cnt == '0);
    assign full  = cnt[AW];
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    // Head word is masked while empty so the output is quiet after reset/flush.
    assign dout  = empty ? '0 : mem[rp];

    // Pointer and occupancy tracking; clear discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end
    end

    // Storage array; contents need no reset since reads are masked when empty.
    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wp] <= din;
    end

endmodule

// File: rtl/mmu_tx_bd_dispatch.sv
// Steers single-beat BDs to per-channel FWFT queues using the channel-id field,
// with per-channel credit limits, channel enables, bad-BD drop/stall and flush.
module mmu_tx_bd_dispatch
    import mmu_tx_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int BD_W      = 512,
    parameter int CH_LSB    = CH_LSB_DEF,
    parameter int CHW       = CHW_DEF,
    parameter int FIFO_AW   = 5,
    parameter int AFULL_LVL = 28,
    parameter int MAX_OUTS  = 16
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic [BD_W-1:0]          s_bd_tdata,
    input  logic                     s_bd_tvalid,
    output logic                     s_bd_tready,
    output logic [NUM_CH*BD_W-1:0]   m_bd_tdata,
    output logic [NUM_CH-1:0]        m_bd_tvalid,
    input  logic [NUM_CH-1:0]        m_bd_tready,
    input  logic                     rsp_en,
    input  logic [CHW-1:0]           rsp_ch,
    input  logic [NUM_CH-1:0]        cfg_ch_en,
    input  logic                     cfg_drop_bad,
    input  logic                     cfg_flush,
    output logic [NUM_CH*OUTS_W-1:0] sta_outs,
    output logic [31:0]              sta_bd_cnt,
    output logic [15:0]              sta_drop_cnt,
    output logic                     err_bad_ch,
    output logic                     err_rsp_unf,
    output logic [1:0]               sta_fsm
);

    localparam int CW = FIFO_AW + 1;

    fsm_t st, st_nxt;

    logic                               in_vld;
    logic [BD_W-1:0]                    in_data;
    logic [CHW-1:0]                     ch;
    logic [NUM_CH-1:0][OUTS_W-1:0]      outs;
    logic [NUM_CH-1:0][CW-1:0]          fifo_cnt;
    logic [NUM_CH-1:0]                  fifo_empty;

    logic              ch_ok, en_sel, rsp_ok;
    logic [CW-1:0]     cnt_sel;
    logic [OUTS_W-1:0] outs_sel, rsp_outs_sel;
    logic              run, bad, blk, go, drop, stall_bad, bad_seen;
    logic              acc, flush_clr, rsp_act, rsp_dec;

    assign ch = in_data[CH_LSB +: CHW];

    // Look up per-channel state for the held BD and for the response channel.
    always_comb begin
        ch_ok        = 1'b0;
        en_sel       = 1'b0;
        cnt_sel      = '0;
        outs_sel     = '0;
        rsp_ok       = 1'b0;
        rsp_outs_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CHW'(i)) begin
                ch_ok    = 1'b1;
                en_sel   = cfg_ch_en[i];
                cnt_sel  = fifo_cnt[i];
                outs_sel = outs[i];
            end
            if (rsp_ch == CHW'(i)) begin
                rsp_ok       = 1'b1;
                rsp_outs_sel = outs[i];
            end
        end
    end

    assign run       = (st == ST_RUN);
    assign bad       = ~ch_ok | ~en_sel;
    assign blk       = (cnt_sel >= CW'(AFULL_LVL)) | (outs_sel == OUTS_W'(MAX_OUTS));
    // A dispatch on the flush request cycle would be wiped by the clear, so hold it off.
    assign go        = in_vld & ~bad & ~blk & run & ~cfg_flush;
    assign drop      = in_vld & bad & cfg_drop_bad & run;
    assign stall_bad = in_vld & bad & ~cfg_drop_bad & run;
    // Ready comes from held state only; rst_n keeps it low while in reset.
    assign s_bd_tready = rst_n & run & (~in_vld | go | drop);
    assign acc         = s_bd_tvalid & s_bd_tready;
    // Clear queues/credits on the request edge and through FLUSH.
    assign flush_clr   = (run & cfg_flush) | (st == ST_FLUSH);
    assign err_bad_ch  = drop | (stall_bad & ~bad_seen);
    assign rsp_act     = rsp_en & run & rst_n;
    assign err_rsp_unf = rsp_act & (~rsp_ok | (rsp_outs_sel == '0));
    assign rsp_dec     = rsp_act & rsp_ok & (rsp_outs_sel != '0);
    assign sta_fsm     = st;

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) st <= ST_RUN;
        else        st <= st_nxt;
    end

    // FSM next state: flush is a fixed RUN -> FLUSH -> DRAIN -> RUN walk.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_RUN:   if (cfg_flush) st_nxt = ST_FLUSH;
            ST_FLUSH: st_nxt = ST_DRAIN;
            ST_DRAIN: st_nxt = ST_RUN;
            default:  st_nxt = ST_RUN;
        endcase
    end

    // Input holding register: loads on accept, frees on dispatch or drop.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            in_vld  <= 1'b0;
            in_data <= '0;
        end else begin
            if (flush_clr)        in_vld <= 1'b0;
            else if (acc)         in_vld <= 1'b1;
            else if (go || drop)  in_vld <= 1'b0;
            if (acc) in_data <= s_bd_tdata;
        end
    end

    // Remember a stalled bad BD so its error fires only on the first cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) bad_seen <= 1'b0;
        else        bad_seen <= stall_bad & ~flush_clr;
    end

    // Status counters: dispatched wraps, dropped saturates.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sta_bd_cnt   <= '0;
            sta_drop_cnt <= '0;
        end else begin
            if (go) sta_bd_cnt <= sta_bd_cnt + 32'd1;
            if (drop && sta_drop_cnt != 16'hFFFF) sta_drop_cnt <= sta_drop_cnt + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              inc, dec;
        logic [OUTS_W-1:0] outs_q;

        assign inc = go & (ch == CHW'(i));
        assign dec = rsp_dec & (rsp_ch == CHW'(i));
        assign outs[i] = outs_q;
        assign sta_outs[i*OUTS_W +: OUTS_W] = outs_q;
        assign m_bd_tvalid[i] = ~fifo_empty[i];

        // Outstanding credits: dispatch adds, response releases, both cancel.
        always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n)              outs_q <= '0;
            else if (flush_clr)      outs_q <= '0;
            else if (inc && !dec)    outs_q <= outs_q + 1'b1;
            else if (dec && !inc)    outs_q <= outs_q - 1'b1;
        end

        bd_ch_fifo #(.W(BD_W), .AW(FIFO_AW)) u_fifo (
            .clk   (clk_sys),
            .rst_n (rst_n),
            .clr   (flush_clr),
            .push  (inc),
            .din   (in_data),
            .pop   (m_bd_tready[i]),
            .dout  (m_bd_tdata[i*BD_W +: BD_W]),
            .empty (fifo_empty[i]),
            .cnt   (fifo_cnt[i])
        );
    end

endmodule
